// File: rtl/reg_file_2r1w_pkg.sv
// Shared datapath definitions for the architectural register file.
package reg_file_2r1w_pkg;

    localparam int unsigned DataW = 32;
    localparam int unsigned AddrW = 5;

    // Named register indices used by the decoder.
    localparam logic [AddrW-1:0] RegZero = 5'd0;
    localparam logic [AddrW-1:0] RegRa   = 5'd1;
    localparam logic [AddrW-1:0] RegSp   = 5'd2;

endpackage

// File: rtl/reg_file_2r1w_read_port.sv
// One combinational read port: zero register first, then write bypass, then stored word.
module rf_read_port
    import reg_file_2r1w_pkg::*;
#(
    parameter int unsigned DATA_W = DataW,
    parameter int unsigned ADDR_W = AddrW,
    parameter bit          BYPASS = 1'b1
) (
    input  logic [ADDR_W-1:0] raddr_i,
    input  logic [DATA_W-1:0] mem_word_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic raddr_zero;
    logic bypass_hit;

    assign raddr_zero = (raddr_i == ADDR_W'(RegZero));
    assign bypass_hit = BYPASS && we_i && (waddr_i != ADDR_W'(RegZero)) && (raddr_i == waddr_i);

    always_comb begin
        rdata_o = mem_word_i;
        if (raddr_zero) begin
            rdata_o = '0;
        end else if (bypass_hit) begin
            rdata_o = wdata_i;
        end
    end

endmodule

// File: rtl/reg_file_2r1w.sv
// Two-read / one-write register file with hardwired zero register and optional write bypass.
module reg_file_2r1w
    import reg_file_2r1w_pkg::*;
#(
    parameter int unsigned DATA_W = DataW,
    parameter int unsigned ADDR_W = AddrW,
    parameter bit          BYPASS = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_a_i,
    input  logic [ADDR_W-1:0] raddr_b_i,
    output logic [DATA_W-1:0] rdata_a_o,
    output logic [DATA_W-1:0] rdata_b_o,
    output logic              wr_zero_err_o
);

    localparam int unsigned Depth = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [Depth];
    logic              wr_zero_err_q, wr_zero_err_d;
    logic              wr_en;
    logic              wr_zero;
    logic              we_eff;

    assign wr_zero = (waddr_i == ADDR_W'(RegZero));
    assign wr_en   = we_i && !wr_zero;
    // Bypass is suppressed while in reset so reads stay zero even with we high.
    assign we_eff  = we_i && rst_ni;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        wr_zero_err_d = wr_zero_err_q;
        if (we_i && wr_zero) begin
            wr_zero_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_zero_err_q <= 1'b0;
        end else begin
            wr_zero_err_q <= wr_zero_err_d;
        end
    end

    assign wr_zero_err_o = wr_zero_err_q;

    rf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_port_a (
        .raddr_i    (raddr_a_i),
        .mem_word_i (mem_q[raddr_a_i]),
        .we_i       (we_eff),
        .waddr_i    (waddr_i),
        .wdata_i    (wdata_i),
        .rdata_o    (rdata_a_o)
    );

    rf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_port_b (
        .raddr_i    (raddr_b_i),
        .mem_word_i (mem_q[raddr_b_i]),
        .we_i       (we_eff),
        .waddr_i    (waddr_i),
        .wdata_i    (wdata_i),
        .rdata_o    (rdata_b_o)
    );

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Scoreboard bench for reg_file_2r1w: one bypassing and one non-bypassing instance share stimulus.
module tb_reg_file_2r1w;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        we_i;
    logic [4:0]  waddr_i, raddr_a_i, raddr_b_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_a_o, rdata_b_o, nb_rdata_a_o, nb_rdata_b_o;
    logic        wr_zero_err_o, nb_wr_zero_err_o;

    always #5 clk_i = ~clk_i;

    reg_file_2r1w #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .we_i          (we_i),
        .waddr_i       (waddr_i),
        .wdata_i       (wdata_i),
        .raddr_a_i     (raddr_a_i),
        .raddr_b_i     (raddr_b_i),
        .rdata_a_o     (rdata_a_o),
        .rdata_b_o     (rdata_b_o),
        .wr_zero_err_o (wr_zero_err_o)
    );

    reg_file_2r1w #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) dut_nb (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .we_i          (we_i),
        .waddr_i       (waddr_i),
        .wdata_i       (wdata_i),
        .raddr_a_i     (raddr_a_i),
        .raddr_b_i     (raddr_b_i),
        .rdata_a_o     (nb_rdata_a_o),
        .rdata_b_o     (nb_rdata_b_o),
        .wr_zero_err_o (nb_wr_zero_err_o)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] a_nb;
        logic [31:0] b_nb;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mdl [32];
    logic        mdl_err;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h want %08h", tag, obs, exp);
        end
    endtask

    task automatic mdl_clear();
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        mdl_err = 1'b0;
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] ra, input bit byp);
        if (!rst_ni || ra == 5'd0) return '0;
        if (byp && we_i && waddr_i != 5'd0 && ra == waddr_i) return wdata_i;
        return mdl[ra];
    endfunction

    // Drive one cycle, predict pre-edge outputs, compare at negedge, advance model at posedge.
    task automatic cycle(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra, input logic [4:0] rb);
        exp_t e;
        we_i = we; waddr_i = wa; wdata_i = wd; raddr_a_i = ra; raddr_b_i = rb;
        sb_q.push_back('{exp_rd(ra, 1'b1), exp_rd(rb, 1'b1),
                         exp_rd(ra, 1'b0), exp_rd(rb, 1'b0), mdl_err});
        @(negedge clk_i);
        e = sb_q.pop_front();
        check_val("rd_a", rdata_a_o, e.a);
        check_val("rd_b", rdata_b_o, e.b);
        check_val("nb_rd_a", nb_rdata_a_o, e.a_nb);
        check_val("nb_rd_b", nb_rdata_b_o, e.b_nb);
        check_val("zero_err", {31'd0, wr_zero_err_o}, {31'd0, e.err});
        @(posedge clk_i);
        if (rst_ni && we) begin
            if (wa != 5'd0) mdl[wa] = wd;
            else mdl_err = 1'b1;
        end
        #1;
    endtask

    task automatic peek(input string tag, input logic [4:0] ra, input logic [4:0] rb,
                        input logic [31:0] ea, input logic [31:0] eb);
        we_i = 1'b0; raddr_a_i = ra; raddr_b_i = rb;
        #1;
        check_val({tag, "_a"}, rdata_a_o, ea);
        check_val({tag, "_b"}, rdata_b_o, eb);
        check_val({tag, "_nb_a"}, nb_rdata_a_o, ea);
        check_val({tag, "_nb_b"}, nb_rdata_b_o, eb);
    endtask

    initial begin
        logic [4:0] wa, ra, rb;
        rst_ni = 1'b0; we_i = 1'b0; waddr_i = '0; wdata_i = '0;
        raddr_a_i = '0; raddr_b_i = '0;
        mdl_clear();
        @(posedge clk_i); #1;
        cycle(1'b1, 5'd5, 32'h0BAD_F00D, 5'd5, 5'd31);
        rst_ni = 1'b1;
        peek("por", 5'd5, 5'd31, 32'h0, 32'h0);
        check_val("por_err", {31'd0, wr_zero_err_o}, 32'd0);

        // Basic write/read.
        cycle(1'b1, 5'd7, 32'h1234_5678, 5'd0, 5'd0);
        peek("wr7", 5'd7, 5'd7, 32'h1234_5678, 32'h1234_5678);
        peek("r6r8", 5'd6, 5'd8, 32'h0, 32'h0);

        // Mid-run reset after writing r5.
        cycle(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd7);
        peek("r5", 5'd5, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        #2 rst_ni = 1'b0;
        mdl_clear();
        peek("rst_hold", 5'd5, 5'd7, 32'h0, 32'h0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        peek("rst_rel", 5'd5, 5'd5, 32'h0, 32'h0);
        check_val("rst_err", {31'd0, wr_zero_err_o}, 32'd0);

        // Write to zero register sets sticky flag.
        cycle(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        check_val("zwr_err", {31'd0, wr_zero_err_o}, 32'd1);
        peek("zwr_rd", 5'd0, 5'd0, 32'h0, 32'h0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 5'd0, 32'h0, 5'($urandom), 5'd0);
        check_val("zwr_sticky", {31'd0, wr_zero_err_o}, 32'd1);

        // Bypass versus stored value.
        cycle(1'b1, 5'd3, 32'h1111_1111, 5'd0, 5'd0);
        cycle(1'b1, 5'd4, 32'h0000_0044, 5'd0, 5'd0);
        we_i = 1'b1; waddr_i = 5'd3; wdata_i = 32'h2222_2222; raddr_a_i = 5'd3; raddr_b_i = 5'd4;
        #1;
        check_val("byp_a", rdata_a_o, 32'h2222_2222);
        check_val("byp_b", rdata_b_o, 32'h0000_0044);
        check_val("nbyp_a", nb_rdata_a_o, 32'h1111_1111);
        cycle(1'b1, 5'd3, 32'h2222_2222, 5'd3, 5'd4);
        peek("after_byp", 5'd3, 5'd4, 32'h2222_2222, 32'h0000_0044);
        cycle(1'b1, 5'd10, 32'hCAFE_0010, 5'd10, 5'd10);
        cycle(1'b1, 5'd0, 32'h1357_9BDF, 5'd0, 5'd0);

        // Reset asserted during a write: reset wins, bypass suppressed.
        we_i = 1'b1; waddr_i = 5'd9; wdata_i = 32'hA5A5_A5A5; raddr_a_i = 5'd9; raddr_b_i = 5'd9;
        #2 rst_ni = 1'b0;
        mdl_clear();
        #1;
        check_val("race_hold_a", rdata_a_o, 32'h0);
        check_val("race_hold_b", rdata_b_o, 32'h0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        peek("race_rel", 5'd9, 5'd9, 32'h0, 32'h0);
        check_val("race_err", {31'd0, wr_zero_err_o}, 32'd0);

        // Random sweep against the reference model.
        for (int i = 0; i < 2000; i++) begin
            wa = 5'($urandom);
            ra = 5'($urandom);
            rb = 5'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                ra = wa;
                rb = wa;
            end
            cycle(1'($urandom_range(0, 3) != 0), wa, $urandom, ra, rb);
        end
        for (int i = 0; i < 32; i++) begin
            cycle(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- Architectural register file for the single-cycle datapath.
- Sits directly upstream of the operand-select muxes: read-port data feeds the per-bit 4:1 select stage that chooses ALU operands and the writeback source.
- Two combinational read ports and one synchronous write port.
- Register 0 is hardwired to zero.
- Same-cycle write-to-read bypass, so a value written this cycle appears on the read ports before the clock edge.

Parameters:
- DATA_W, 32, width of each register in bits.
- ADDR_W, 5, register address width; depth = 2**ADDR_W.
- BYPASS, 1, 1 = enable write-to-read forwarding; 0 = read the stored value only.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- we  input  1  write enable, sampled on rising clk.
- waddr  input  ADDR_W  write address.
- wdata  input  DATA_W  write data.
- raddr_a  input  ADDR_W  read port A address.
- raddr_b  input  ADDR_W  read port B address.
- rdata_a  output  DATA_W  read port A data (combinational).
- rdata_b  output  DATA_W  read port B data (combinational).
- wr_zero_err  output  1  registered flag: a write to address 0 was attempted.

Behaviour:
- Reset:
  - rst_n low asynchronously clears all 2**ADDR_W registers to 0 and wr_zero_err to 0.
  - While rst_n is low, rdata_a and rdata_b read 0 and writes are ignored, including when we is high.
  - Deassertion takes effect at the next rising clk edge.
- Write:
  - On rising clk with rst_n high, we=1 and waddr!=0: mem[waddr] <= wdata.
  - One write per cycle; no read-modify-write.
- Writes to address 0:
  - we=1 with waddr=0 leaves mem unchanged.
  - wr_zero_err <= 1 on that edge. It is sticky until reset.
  - wr_zero_err is diagnostic only; datapath behaviour is unaffected.
- Read:
  - Purely combinational, zero-cycle latency from raddr to rdata.
  - raddr=0 returns 0 regardless of mem contents or bypass.
- Bypass (BYPASS=1):
  - If we=1, waddr!=0 and raddr_x==waddr, then rdata_x = wdata in the same cycle.
  - Evaluated independently per port, so both ports may bypass at once.
- No bypass (BYPASS=0): rdata_x = mem[raddr_x] (the old value) until after the edge.
- Simultaneous events:
  - A and B reading the same address return identical data.
  - Write and read to the same address with BYPASS=0 returns the old value this cycle and the new value from the next cycle.
  - Reset asserted in the same cycle as a write: reset wins and the register stays 0.
- Width rules:
  - Unknown or X addresses are not masked, so they propagate X.
  - Full address space is legal; no out-of-range condition exists.
- Expected size: ~150 lines. Storage array, write logic, two read-port instances, sticky flag.

Decomposition:
- Shared package (datapath defs): DATA_W=32, ADDR_W=5, REG_ZERO=0. Named register-index constants (ZERO, RA, SP) used by the decoder.
- Sub-module rf_read_port, instantiated twice. Inputs: raddr, mem word, we, waddr, wdata. It applies the zero-register and bypass priority: zero, then bypass, then stored value.

Test Plan:
- Reset check: assert rst_n=0 mid-run after writing 0xDEADBEEF to r5, release, read r5 via A and B -> both 0x00000000; wr_zero_err=0.
- Basic write/read: we=1, waddr=7, wdata=0x12345678, edge; then raddr_a=7, raddr_b=7 -> both 0x12345678. r6 and r8 remain 0.
- Zero register: we=1, waddr=0, wdata=0xFFFFFFFF, edge -> rdata_a(raddr=0)=0. wr_zero_err=1 after the edge and stays 1 across 10 further cycles.
- Bypass: r3 holds 0x11111111; in one cycle drive we=1, waddr=3, wdata=0x22222222, raddr_a=3, raddr_b=4 (r4 holds 0x44) -> before the edge rdata_a=0x22222222, rdata_b=0x00000044. Repeat with BYPASS=0 -> rdata_a=0x11111111 before the edge and 0x22222222 after.
- Reset races write: rst_n falls in the same cycle as we=1, waddr=9, wdata=0xA5A5A5A5 -> r9 reads 0 after release.
- Random sweep: 2000 cycles of random we/waddr/wdata/raddr checked against a reference model, covering all 32 addresses, both-port bypass, and waddr=raddr_a=raddr_b.
